ioctl_upload_server: RTL and testbench

//  Core-side responder for the HPS ioctl upload direction: saves NVRAM or hiscore data from core RAM to the HPS.

---
 rtl/ioctl_pkg.sv | 13 +
 rtl/ioctl_upload_server.sv | 157 +++++++++++++++
 tb/tb_ioctl_upload_server.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_pkg.sv
// Shared ioctl definitions: upload FSM states, HPS address width, file index constants.
package ioctl_pkg;

  typedef enum logic [1:0] {UP_IDLE, UP_REQ, UP_LAT} upl_state_t;

  localparam int unsigned IOCTL_AW = 25;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_MOD   = 8'd1;
  localparam logic [7:0] IDX_NVRAM = 8'd4;
  localparam logic [7:0] IDX_DIP   = 8'd254;

endpackage

// File: rtl/ioctl_upload_server.sv
// Core-side responder for ioctl uploads (NVRAM/hiscore save): turns each HPS
// read strobe into one arbitrated core-RAM read and stalls the HPS with
// ioctl_wait until the byte is valid. Addresses at or above SIZE return 8'h00
// without touching memory.
// Optional build macro UPLOAD_CHECKSUM_EN adds upl_csum, a mod-256 sum of the
// bytes delivered in the current/last session.
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter logic [7:0]  UPL_INDEX = IDX_NVRAM,
  parameter int unsigned AW        = 10,
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [AW-1:0]       mem_addr,
  input  logic [7:0]          mem_q,
`ifdef UPLOAD_CHECKSUM_EN
  output logic [7:0]          upl_csum,
`endif
  output logic                upl_busy
);

  // Latency counter holds RD_LAT-1 (at most 3).
  localparam int unsigned CNT_W = 2;

  upl_state_t         state_q, state_d;
  logic [7:0]         din_q, din_d;
  logic               wait_q, wait_d;
  logic               req_q, req_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;
  logic               sel_c;
  logic               oor_c;
  logic               load_c;

  assign sel_c = ioctl_upload && (ioctl_index == UPL_INDEX);
  assign oor_c = ioctl_addr >= IOCTL_AW'(SIZE);

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= UP_IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= sel_c;
    end
  end

  // Next-state: accept read, wait for grant, count out read latency; a
  // deselect in REQ/LAT aborts and wins over a same-cycle grant or capture.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    case (state_q)
      UP_IDLE: begin
        if (ioctl_rd && sel_c) begin
          if (oor_c) begin
            din_d  = 8'h00;
            load_c = 1'b1;
          end else begin
            addr_d  = ioctl_addr[AW-1:0];
            req_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = UP_REQ;
          end
        end
      end
      UP_REQ: begin
        if (!sel_c) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = UP_IDLE;
        end else if (mem_gnt) begin
          req_d   = 1'b0;
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = UP_LAT;
        end
      end
      UP_LAT: begin
        if (!sel_c) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = UP_IDLE;
        end else if (cnt_q == '0) begin
          din_d   = mem_q;
          wait_d  = 1'b0;
          load_c  = 1'b1;
          state_d = UP_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        wait_d  = 1'b0;
        state_d = UP_IDLE;
      end
    endcase
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Session checksum: cleared as sel rises, accumulates each delivered byte.
  always_comb begin
    csum_d = (sel_c && !busy_q) ? 8'h00 : csum_q;
    if (load_c) begin
      csum_d = csum_d + din_d;
    end
  end

  // Checksum register; holds after the session ends.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign upl_csum = csum_q;
`endif

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign upl_busy   = busy_q;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server with a latency-pipelined RAM model
// and a scoreboard of expected ioctl_din bytes. Define UPLOAD_CHECKSUM_EN to
// also exercise upl_csum.
module tb_ioctl_upload_server;

  localparam int unsigned AW     = 10;
  localparam int unsigned SIZE   = 1024;
  localparam int unsigned RD_LAT = 2;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q;
  logic          upl_busy;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]    upl_csum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram  [SIZE];
  logic [7:0] pipe [RD_LAT];
  logic [7:0] exp_q [$];

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_server #(
    .UPL_INDEX(8'd4), .AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q),
`ifdef UPLOAD_CHECKSUM_EN
    .upl_csum     (upl_csum),
`endif
    .upl_busy     (upl_busy)
  );

  // RAM model: data for a granted request appears RD_LAT cycles after the grant cycle.
  always @(posedge clk_sys) begin
    pipe[0] <= (mem_req && mem_gnt) ? ram[mem_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [24:0] addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    exp_q.push_back((addr >= 25'(SIZE)) ? 8'h00 : ram[a]);
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk(tag, 32'(ioctl_din), 32'(exp_q.pop_front()));
  endtask

  // One HPS read with grant withheld for gnt_delay request cycles.
  task automatic do_read(input logic [24:0] addr, input int gnt_delay, input string tag);
    int  req_n = 0, wait_n = 0, addr_bad = 0, cyc = 0;
    bit  done = 0;
    bit  oor;
    oor = (addr >= 25'(SIZE));
    sb_push(addr);
    @(negedge clk_sys);
    ioctl_rd = 1'b1; ioctl_addr = addr; mem_gnt = (gnt_delay == 0);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    while (!done && cyc < 50) begin
      if (mem_req === 1'b1) begin
        req_n++;
        if (mem_addr !== addr[AW-1:0]) addr_bad++;
        if (req_n == gnt_delay + 1) mem_gnt = 1'b1;
      end else if (gnt_delay != 0) begin
        mem_gnt = 1'b0;
      end
      if (ioctl_wait === 1'b1) wait_n++;
      else done = 1;
      cyc++;
      if (!done) @(negedge clk_sys);
    end
    mem_gnt = 1'b1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_req_cycles"}, 32'(req_n), oor ? 32'd0 : 32'(gnt_delay + 1));
    chk({tag, "_wait_cycles"}, 32'(wait_n), oor ? 32'd0 : 32'(gnt_delay + 1 + RD_LAT));
    chk({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
    sb_check({tag, "_din"});
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) ram[i] = 8'(i * 7 + 3);
    ram[5] = 8'hA5; ram[7] = 8'h3C; ram[8] = 8'h81;
    ram[16] = 8'h01; ram[17] = 8'h02; ram[18] = 8'hFF;

    reset = 1'b1; ioctl_upload = 1'b1; ioctl_index = 8'd4;
    ioctl_rd = 1'b0; ioctl_addr = '0; mem_gnt = 1'b1;
    @(negedge clk_sys); @(negedge clk_sys);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(upl_busy), 32'd0);
`ifdef UPLOAD_CHECKSUM_EN
    chk("rst_csum", 32'(upl_csum), 32'h00);
`endif
    reset = 1'b0;
    @(negedge clk_sys);
    chk("busy_on", 32'(upl_busy), 32'd1);

    // Basic reads, grant timing variations, and top in-range address.
    do_read(25'd5, 0, "t1");
    do_read(25'd100, 4, "t2");
    do_read(25'd1023, 0, "top");
    do_read(25'd0, 1, "zero");

    // Out-of-range addresses return zero-fill without memory access.
    do_read(25'd1024, 0, "oor1024");
    do_read(25'h1FFFFFF, 0, "oormax");

    // Upload dropped during LAT: abort, din keeps previous byte.
    do_read(25'd7, 0, "t4pre");
    @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd8; mem_gnt = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("t4_wait", 32'(ioctl_wait), 32'd0);
    chk("t4_req", 32'(mem_req), 32'd0);
    chk("t4_din", 32'(ioctl_din), 32'h3C);
    @(negedge clk_sys); @(negedge clk_sys);
    chk("t4_din_hold", 32'(ioctl_din), 32'h3C);
    chk("t4_busy", 32'(upl_busy), 32'd0);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    do_read(25'd8, 0, "t4post");

    // Abort and grant in the same cycle: abort wins, nothing captured.
    @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd9; mem_gnt = 1'b0;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    chk("ag_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("ag_req_off", 32'(mem_req), 32'd0);
    chk("ag_wait", 32'(ioctl_wait), 32'd0);
    @(negedge clk_sys); @(negedge clk_sys); @(negedge clk_sys);
    chk("ag_din", 32'(ioctl_din), 32'h81);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // Wrong index: strobes are ignored.
    ioctl_index = 8'd0;
    @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd12;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    chk("t5_req", 32'(mem_req), 32'd0);
    chk("t5_wait", 32'(ioctl_wait), 32'd0);
    chk("t5_busy", 32'(upl_busy), 32'd0);
    ioctl_rd = 1'b1; ioctl_addr = 25'd2000;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    @(negedge clk_sys);
    chk("t5_req2", 32'(mem_req), 32'd0);
    chk("t5_din", 32'(ioctl_din), 32'h81);
    ioctl_index = 8'd4;
    @(negedge clk_sys); @(negedge clk_sys);
    chk("t5_busy_back", 32'(upl_busy), 32'd1);

`ifdef UPLOAD_CHECKSUM_EN
    // New session clears the checksum; 01+02+FF+00 = 02.
    ioctl_upload = 1'b0;
    @(negedge clk_sys); @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("cs_clear", 32'(upl_csum), 32'h00);
    do_read(25'd16, 0, "cs_b0");
    do_read(25'd17, 0, "cs_b1");
    do_read(25'd18, 0, "cs_b2");
    do_read(25'd2000, 0, "cs_b3");
    chk("cs_sum", 32'(upl_csum), 32'h02);
    ioctl_upload = 1'b0;
    @(negedge clk_sys); @(negedge clk_sys);
    chk("cs_hold", 32'(upl_csum), 32'h02);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("cs_reclear", 32'(upl_csum), 32'h00);
`endif

    // Asynchronous reset mid-request clears outputs immediately.
    @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd10; mem_gnt = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    chk("ar_req_pre", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_wait", 32'(ioctl_wait), 32'd0);
    chk("ar_din", 32'(ioctl_din), 32'h00);
    chk("ar_addr", 32'(mem_addr), 32'd0);
    chk("ar_busy", 32'(upl_busy), 32'd0);
    @(negedge clk_sys); reset = 1'b0;
    @(negedge clk_sys); @(negedge clk_sys); @(negedge clk_sys);
    chk("ar_idle_wait", 32'(ioctl_wait), 32'd0);
    chk("ar_idle_din", 32'(ioctl_din), 32'h00);
    do_read(25'd10, 0, "ar_post");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
